// File: rtl/ps2_keyboard_port.sv
// ps2_keyboard_port: PS/2 device-to-host receiver with make-code filter and
// scan-code FIFO, presented as LC-3 style KBSR/KBDR words. Rev 1.0
`default_nettype none

module ps2_keyboard_port #(
  parameter int FIFO_DEPTH     = 4,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  input  logic        KBSR_Read,
  input  logic        KBDR_Read,
  output logic [15:0] KBSR,
  output logic [15:0] KBDR
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [FW-1:0] c_FLT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] c_TO_MAX  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] c_PTR_MAX = PW'(FIFO_DEPTH - 1);
  localparam logic [2:0]    c_DEPTH   = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_filt, r_clk_filt_d;
  logic [FW-1:0] r_flt_cnt;
  logic          w_sample;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;
  logic          w_timeout, w_stop, w_frame_ok;

  logic          r_byte_vld;
  logic [7:0]    r_byte;
  logic          r_break_pending;
  logic          w_push;

  logic [7:0]    r_mem [0:(1<<PW)-1];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [2:0]    r_count;
  logic          w_full, w_pop, w_do_push, w_ovf_set, w_err_set;
  logic          r_ovf, r_err;

  // Two-flop synchronisers followed by a run-length glitch filter on the clock
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_clk_s1     <= 1'b1;
      r_clk_s2     <= 1'b1;
      r_dat_s1     <= 1'b1;
      r_dat_s2     <= 1'b1;
      r_clk_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
      r_flt_cnt    <= '0;
    end else begin
      r_clk_s1     <= PS2_CLK;
      r_clk_s2     <= r_clk_s1;
      r_dat_s1     <= PS2_DATA;
      r_dat_s2     <= r_dat_s1;
      r_clk_filt_d <= r_clk_filt;
      if (r_clk_s2 == r_clk_filt) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == c_FLT_MAX) begin
        r_clk_filt <= r_clk_s2;
        r_flt_cnt  <= '0;
      end else begin
        r_flt_cnt <= r_flt_cnt + 1'b1;
      end
    end
  end

  assign w_sample   = r_clk_filt_d & ~r_clk_filt;
  assign w_frame_ok = (^{r_shift, r_parity}) & r_dat_s2;

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_stop      = 1'b0;
    case (r_state)
      S_IDLE:   if (w_sample && !r_dat_s2) w_state_nxt = S_DATA;
      S_DATA:   if (w_sample && r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
      S_PARITY: if (w_sample) w_state_nxt = S_STOP;
      S_STOP: begin
        if (w_sample) begin
          w_state_nxt = S_IDLE;
          w_stop      = 1'b1;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
    if (r_state != S_IDLE && !w_sample && r_to_cnt == c_TO_MAX) begin
      w_timeout   = 1'b1;
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_to_cnt   <= '0;
      r_byte_vld <= 1'b0;
      r_byte     <= '0;
    end else begin
      r_byte_vld <= 1'b0;
      if (r_state == S_IDLE || w_timeout || w_sample) r_to_cnt <= '0;
      else                                            r_to_cnt <= r_to_cnt + 1'b1;
      if (w_sample) begin
        case (r_state)
          S_IDLE:   r_bitcnt <= '0;
          S_DATA: begin
            r_shift  <= {r_dat_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
          end
          S_PARITY: r_parity <= r_dat_s2;
          default: begin
            r_byte_vld <= w_frame_ok;
            r_byte     <= r_shift;
          end
        endcase
      end
    end
  end

  // Release codes arm break_pending so the following make code is swallowed
  assign w_push = r_byte_vld && (r_byte != 8'hF0) && (r_byte != 8'hE0) && !r_break_pending;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_break_pending <= 1'b0;
    end else if (r_byte_vld) begin
      if (r_byte == 8'hF0)      r_break_pending <= 1'b1;
      else if (r_byte != 8'hE0) r_break_pending <= 1'b0;
    end
  end

  assign w_full    = (r_count == c_DEPTH);
  assign w_pop     = KBDR_Read && (r_count != 3'd0);
  assign w_do_push = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;
  assign w_err_set = (w_stop && !w_frame_ok) || w_timeout;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= r_byte;
        r_wr_ptr        <= (r_wr_ptr == c_PTR_MAX) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= (r_rd_ptr == c_PTR_MAX) ? '0 : r_rd_ptr + 1'b1;
      if (w_do_push && !w_pop)      r_count <= r_count + 3'd1;
      else if (w_pop && !w_do_push) r_count <= r_count - 3'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (KBSR_Read) r_ovf <= 1'b0;
      if (w_err_set)      r_err <= 1'b1;
      else if (KBSR_Read) r_err <= 1'b0;
    end
  end

  assign KBSR = {(r_count != 3'd0), r_ovf, r_err, 10'd0, r_count};
  assign KBDR = (r_count != 3'd0) ? {8'h00, r_mem[r_rd_ptr]} : 16'h0000;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard_port.sv
// tb_ps2_keyboard_port: directed PS/2 frames with a queue-based scoreboard on
// every change of the {KBSR,KBDR} pair. Rev 1.0
`default_nettype none

module tb_ps2_keyboard_port;

  logic        Clk = 1'b0;
  logic        Reset, PS2_CLK, PS2_DATA, KBSR_Read, KBDR_Read;
  logic [15:0] KBSR, KBDR;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] prev;
  logic        mon_en = 1'b0;

  ps2_keyboard_port #(
    .FIFO_DEPTH(4),
    .FILTER_LEN(4),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .PS2_CLK(PS2_CLK),
    .PS2_DATA(PS2_DATA),
    .KBSR_Read(KBSR_Read),
    .KBDR_Read(KBDR_Read),
    .KBSR(KBSR),
    .KBDR(KBDR)
  );

  always #5 Clk = ~Clk;

  // Monitor: each change of the visible register pair consumes one expectation
  always @(negedge Clk) begin
    if (mon_en && {KBSR, KBDR} != prev) begin
      logic [31:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_change: got KBSR=%h KBDR=%h, required no change from KBSR=%h KBDR=%h",
                 KBSR, KBDR, prev[31:16], prev[15:0]);
      end else begin
        e = exp_q.pop_front();
        if ({KBSR, KBDR} !== e) begin
          n_err++;
          $display("FAIL change_%0d: got KBSR=%h KBDR=%h, required KBSR=%h KBDR=%h",
                   n_cmp, KBSR, KBDR, e[31:16], e[15:0]);
        end
      end
      prev = {KBSR, KBDR};
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic expect_regs(input logic [15:0] sr, input logic [15:0] dr);
    exp_q.push_back({sr, dr});
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DATA = b;
    idle(10);
    PS2_CLK = 1'b0;
    idle(20);
    PS2_CLK = 1'b1;
    idle(10);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ flip);
    ps2_bit(1'b1);
    PS2_DATA = 1'b1;
    idle(20);
  endtask

  task automatic pulse_kbdr;
    KBDR_Read = 1'b1;
    idle(1);
    KBDR_Read = 1'b0;
    idle(4);
  endtask

  task automatic pulse_kbsr;
    KBSR_Read = 1'b1;
    idle(1);
    KBSR_Read = 1'b0;
    idle(4);
  endtask

  initial begin
    Reset = 1'b1; PS2_CLK = 1'b1; PS2_DATA = 1'b1; KBSR_Read = 1'b0; KBDR_Read = 1'b0;
    idle(5);
    Reset = 1'b0;
    idle(1);
    n_cmp++;
    if ({KBSR, KBDR} !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: got KBSR=%h KBDR=%h, required KBSR=0000 KBDR=0000", KBSR, KBDR);
    end
    prev   = 32'h0;
    mon_en = 1'b1;

    // 1: glitch ignored, single make code, pop
    PS2_CLK = 1'b0; idle(2); PS2_CLK = 1'b1; idle(10);
    expect_regs(16'h8001, 16'h001C);
    send_frame(8'h1C, 1'b0);
    expect_regs(16'h0000, 16'h0000);
    pulse_kbdr();

    // 2: release and extended-release sequences are swallowed
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    expect_regs(16'h8001, 16'h001D);
    send_frame(8'h1D, 1'b0);
    expect_regs(16'h0000, 16'h0000);
    pulse_kbdr();

    // 3: parity error
    expect_regs(16'h2000, 16'h0000);
    send_frame(8'h1C, 1'b1);
    expect_regs(16'h0000, 16'h0000);
    pulse_kbsr();

    // 4: fill, overflow, drain in order
    expect_regs(16'h8001, 16'h0015); send_frame(8'h15, 1'b0);
    expect_regs(16'h8002, 16'h0015); send_frame(8'h1D, 1'b0);
    expect_regs(16'h8003, 16'h0015); send_frame(8'h24, 1'b0);
    expect_regs(16'h8004, 16'h0015); send_frame(8'h2D, 1'b0);
    expect_regs(16'hC004, 16'h0015); send_frame(8'h2C, 1'b0);
    expect_regs(16'hC003, 16'h001D); pulse_kbdr();
    expect_regs(16'hC002, 16'h0024); pulse_kbdr();
    expect_regs(16'hC001, 16'h002D); pulse_kbdr();
    expect_regs(16'h4000, 16'h0000); pulse_kbdr();
    idle(10);
    expect_regs(16'h0000, 16'h0000); pulse_kbsr();

    // 5: partial frame times out, then a clean frame
    expect_regs(16'h2000, 16'h0000);
    ps2_bit(1'b0);
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    PS2_DATA = 1'b1;
    idle(250);
    expect_regs(16'hA001, 16'h001C);
    send_frame(8'h1C, 1'b0);
    expect_regs(16'h2000, 16'h0000); pulse_kbdr();
    expect_regs(16'h0000, 16'h0000); pulse_kbsr();

    // 6: reset mid-frame leaves no flag, next frame received cleanly
    ps2_bit(1'b0);
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
    PS2_DATA = 1'b0;
    idle(5);
    Reset = 1'b1;
    idle(1);
    Reset = 1'b0;
    PS2_DATA = 1'b1;
    idle(250);
    expect_regs(16'h8001, 16'h0024);
    send_frame(8'h24, 1'b0);

    idle(50);
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing_change: got KBSR=%h KBDR=%h, required KBSR=%h KBDR=%h",
               KBSR, KBDR, e[31:16], e[15:0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps2_keyboard_port.md
Name: ps2_keyboard_port

Overview:
Upstream keyboard front end for the memory-mapped I/O path. It receives PS/2 device-to-host frames and drops key-release and extended-prefix codes. Accepted scan codes are buffered in a small FIFO. The block presents LC-3 style KBSR/KBDR words, and the memory control unit returns them to the CPU for reads of 16'hFE00 and 16'hFE02.

Parameters:
FIFO_DEPTH, 4, number of buffered scan codes (2..7)
FILTER_LEN, 4, consecutive equal samples required before the filtered PS/2 clock changes
TIMEOUT_CYCLES, 5000, system clocks allowed without a PS/2 clock falling edge before a partial frame is aborted

Ports:
Clk  input  1  system clock; all state changes on rising edge
Reset  input  1  synchronous, active-high reset
PS2_CLK  input  1  raw PS/2 clock pin, asynchronous, idle high
PS2_DATA  input  1  raw PS/2 data pin, asynchronous, idle high
KBSR_Read  input  1  one-cycle strobe; CPU read of KBSR (FE00)
KBDR_Read  input  1  one-cycle strobe; CPU read of KBDR (FE02)
KBSR  output  16  status: [15] ready, [14] overflow, [13] frame error, [12:3] 0, [2:0] FIFO count
KBDR  output  16  {8'h00, FIFO head byte}; 16'h0000 when FIFO empty

Behaviour:
- Reset: synchronous, active-high.
  - Sync and filter registers are set to 1.
  - FSM goes to IDLE; bit counter and timeout counter clear.
  - break_pending clears; FIFO empties; sticky flags clear.
  - KBSR=16'h0000, KBDR=16'h0000 on the cycle after Reset is sampled high.
  - Reset mid-frame discards the partial frame and sets no flag.
- Input conditioning:
  - PS2_CLK and PS2_DATA each pass through 2 flops.
  - Filtered clock changes only after FILTER_LEN consecutive equal synced samples; shorter glitches are ignored.
  - A falling edge of the filtered clock produces a one-cycle sample pulse; synced PS2_DATA is captured on that pulse.
- Frame FSM states: IDLE, DATA, PARITY, STOP. Every transition occurs on a sample pulse.
  - IDLE: sampled data 0 (start bit) goes to DATA with bit count 0; sampled data 1 stays in IDLE.
  - DATA: shift bits in LSB first; after the 8th bit, go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: return to IDLE.
    - Frame is valid iff the 8 data bits plus the parity bit contain an odd number of ones AND the stop bit is 1.
    - An invalid frame is discarded and sets sticky error KBSR[13].
- Timeout: in any non-IDLE state, the counter increments each cycle and clears on each sample pulse. On reaching TIMEOUT_CYCLES: go to IDLE, discard the frame, set KBSR[13].
- Valid-byte filter, applied the cycle after the STOP sample:
  - 8'hF0: set break_pending; nothing pushed.
  - 8'hE0: discarded; break_pending unchanged.
  - Other byte with break_pending=1: discarded; break_pending cleared.
  - Other byte otherwise: push request.
- FIFO: circular, FIFO_DEPTH entries, count register.
  - Push when not full. Push when full drops the byte and sets sticky overflow KBSR[14].
  - KBDR_Read with count>0 pops the head; with count=0 it is ignored.
  - Simultaneous push and pop when full: both occur, no overflow.
  - Simultaneous push and pop when empty: push only.
- Outputs: KBSR and KBDR are driven from registers/FIFO storage with no combinational path from the PS/2 pins.
  - KBSR[15] = (count != 0); KBSR[2:0] = count.
  - KBDR reflects the new head the cycle after a pop.
- Latency: a pushed byte is visible in KBDR/KBSR on the second rising edge after the STOP sample pulse.
- Sticky flag clearing:
  - KBSR_Read clears KBSR[14:13] on the next edge.
  - A new error or overflow in the same cycle keeps the flag set (set wins).
  - KBSR_Read has no effect on the FIFO.

Test Plan:
Bench parameters: FIFO_DEPTH=4, FILTER_LEN=4, TIMEOUT_CYCLES=200; PS/2 half-period 20 Clk cycles. Frames are driven with data stable across the falling edge.
1. Frame 8'h1C (parity 0, stop 1), with a 2-cycle low glitch on PS2_CLK before the start bit -> no spurious bit; KBSR=16'h8001, KBDR=16'h001C. Pulse KBDR_Read -> next cycle KBSR=16'h0000, KBDR=16'h0000.
2. Frames F0 then 1C -> KBSR stays 16'h0000. Then frames E0, F0, 1C -> KBSR stays 16'h0000. Then 8'h1D -> KBSR=16'h8001, KBDR=16'h001D.
3. Frame 8'h1C with parity bit 1 -> KBSR=16'h2000, KBDR=16'h0000. Pulse KBSR_Read -> KBSR=16'h0000.
4. Frames 15, 1D, 24, 2D, 2C with no reads -> KBSR=16'hC004, KBDR=16'h0015. Four KBDR_Read pulses -> KBDR sequence 0015, 001D, 0024, 002D, then 0000. KBSR=16'h4000 until KBSR_Read.
5. Start bit plus 4 data bits, then PS2_CLK held high for 250 cycles -> KBSR=16'h2000, FSM in IDLE. Subsequent clean 8'h1C frame -> KBSR=16'hA001, KBDR=16'h001C.
6. Reset pulsed for 1 cycle during data bit 3 of a frame, pins then held idle for 250 cycles -> KBSR=16'h0000. Following 8'h24 frame -> KBSR=16'h8001, KBDR=16'h0024.
